// File: rtl/utm_pkg.sv
// Shared types and constants for the UTM tape controller and its tape store.
// No logic here; latency and backpressure are properties of the importing modules.
package utm_pkg;

    localparam int STATE_W = 3;
    localparam int SYM_W   = 3;

    localparam logic [SYM_W-1:0] SYM_BLANK = 3'b000;
    localparam logic             DIR_LEFT  = 1'b0;
    localparam logic             DIR_RIGHT = 1'b1;

    typedef enum logic [2:0] {
        IDLE,
        FETCH,
        COMMIT,
        HALT,
        FAULT,
        TIMEOUT
    } fsm_t;

    // One response from the combinational transition table.
    typedef struct packed {
        logic [STATE_W-1:0] next_state;
        logic [SYM_W-1:0]   new_sym;
        logic               dir;
    } tbl_rsp_t;

endpackage

// File: rtl/utm_tape.sv
// Tape register file: one synchronous write port, two combinational read ports.
// Writes land on the next edge and reads show the old value that cycle; no backpressure.
module utm_tape
    import utm_pkg::*;
#(
    parameter int TAPE_LEN = 16
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        wr_en,
    input  logic [$clog2(TAPE_LEN)-1:0] wr_addr,
    input  logic [SYM_W-1:0]            wr_sym,
    input  logic [$clog2(TAPE_LEN)-1:0] head_addr,
    output logic [SYM_W-1:0]            head_sym,
    input  logic [$clog2(TAPE_LEN)-1:0] rd_addr,
    output logic [SYM_W-1:0]            rd_sym
);

    logic [SYM_W-1:0] cells [TAPE_LEN];

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < TAPE_LEN; i++) begin
                cells[i] <= SYM_BLANK;
            end
        end else if (wr_en) begin
            cells[wr_addr] <= wr_sym;
        end
    end

    assign head_sym = cells[head_addr];
    assign rd_sym   = cells[rd_addr];

endmodule

// File: rtl/utm_tape_controller.sv
// Sequential host for the UTM transition table: 2 clk per transition (FETCH settle, COMMIT).
// Inputs are ignored while running; UTM_STEP_LIMIT_EN adds a TIMEOUT stop at MAX_STEPS commits.
module utm_tape_controller
    import utm_pkg::*;
#(
    parameter int                 TAPE_LEN   = 16,
    parameter logic [STATE_W-1:0] HALT_STATE = 3'd7
`ifdef UTM_STEP_LIMIT_EN
    ,
    parameter int                 MAX_STEPS  = 255
`endif
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        load_en,
    input  logic [SYM_W-1:0]            load_sym,
    input  logic                        start,
    input  logic                        clear,
    output logic [STATE_W-1:0]          tbl_state,
    output logic [SYM_W-1:0]            tbl_sym,
    input  logic [STATE_W-1:0]          tbl_next_state,
    input  logic [SYM_W-1:0]            tbl_new_sym,
    input  logic                        tbl_dir,
    input  logic [$clog2(TAPE_LEN)-1:0] rd_addr,
    output logic [SYM_W-1:0]            rd_sym,
    output logic [$clog2(TAPE_LEN)-1:0] head_pos,
    output logic [7:0]                  step_count,
    output logic                        running,
    output logic                        halted,
    output logic                        fault
);

    localparam int            AW   = $clog2(TAPE_LEN);
    localparam logic [AW-1:0] LAST = AW'(TAPE_LEN - 1);

    fsm_t               fsm;
    logic [STATE_W-1:0] state;
    logic [AW-1:0]      head;
    logic [AW-1:0]      load_ptr;
    tbl_rsp_t           rsp;
    logic [7:0]         step_inc;
    logic               off_tape;
    logic               wr_en;
    logic [AW-1:0]      wr_addr;
    logic [SYM_W-1:0]   wr_sym;

    assign rsp      = '{next_state: tbl_next_state, new_sym: tbl_new_sym, dir: tbl_dir};
    assign step_inc = (step_count == 8'hFF) ? step_count : step_count + 8'd1;
    assign off_tape = ((head == '0) && (rsp.dir == DIR_LEFT)) ||
                      ((head == LAST) && (rsp.dir == DIR_RIGHT));

    // The single tape write port is shared between serial loading and the commit write.
    always_comb begin
        wr_en   = 1'b0;
        wr_addr = load_ptr;
        wr_sym  = load_sym;
        if (fsm == IDLE && load_en) begin
            wr_en = 1'b1;
        end else if (fsm == COMMIT) begin
            wr_en   = 1'b1;
            wr_addr = head;
            wr_sym  = rsp.new_sym;
        end
    end

    utm_tape #(
        .TAPE_LEN (TAPE_LEN)
    ) u_tape (
        .clk       (clk),
        .rst_n     (rst_n),
        .wr_en     (wr_en),
        .wr_addr   (wr_addr),
        .wr_sym    (wr_sym),
        .head_addr (head),
        .head_sym  (tbl_sym),
        .rd_addr   (rd_addr),
        .rd_sym    (rd_sym)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            fsm        <= IDLE;
            state      <= '0;
            head       <= '0;
            load_ptr   <= '0;
            step_count <= '0;
            running    <= 1'b0;
            halted     <= 1'b0;
            fault      <= 1'b0;
        end else begin
            case (fsm)
                IDLE: begin
                    if (load_en && load_ptr != LAST) begin
                        load_ptr <= load_ptr + AW'(1);
                    end
                    if (start) begin
                        if (state == HALT_STATE) begin
                            fsm    <= HALT;
                            halted <= 1'b1;
                        end else begin
                            fsm     <= FETCH;
                            running <= 1'b1;
                        end
                    end
                end
                FETCH: fsm <= COMMIT;
                COMMIT: begin
                    step_count <= step_inc;
                    if (rsp.next_state == HALT_STATE) begin
                        state   <= HALT_STATE;
                        fsm     <= HALT;
                        running <= 1'b0;
                        halted  <= 1'b1;
                    end else if (off_tape) begin
                        fsm     <= FAULT;
                        running <= 1'b0;
                        fault   <= 1'b1;
                    end else begin
                        head  <= (rsp.dir == DIR_RIGHT) ? head + AW'(1) : head - AW'(1);
                        state <= rsp.next_state;
`ifdef UTM_STEP_LIMIT_EN
                        if (step_inc == 8'(MAX_STEPS)) begin
                            fsm     <= TIMEOUT;
                            running <= 1'b0;
                            fault   <= 1'b1;
                        end else begin
                            fsm <= FETCH;
                        end
`else
                        fsm <= FETCH;
`endif
                    end
                end
                HALT, FAULT, TIMEOUT: begin
                    // Tape contents survive clear so results can still be read back.
                    if (clear) begin
                        fsm        <= IDLE;
                        state      <= '0;
                        head       <= '0;
                        load_ptr   <= '0;
                        step_count <= '0;
                        halted     <= 1'b0;
                        fault      <= 1'b0;
                    end
                end
                default: begin
                    fsm     <= IDLE;
                    running <= 1'b0;
                    halted  <= 1'b0;
                    fault   <= 1'b0;
                end
            endcase
        end
    end

    assign tbl_state = state;
    assign head_pos  = head;

endmodule

// File: tb/tb_utm_tape_controller.sv
// Bench for utm_tape_controller: directed scenarios plus random tables against a tape-level TM model.
module tb_utm_tape_controller;

    localparam int         TL  = 16;
    localparam logic [2:0] HS  = 3'd7;
    localparam int         LIM = 300;
`ifdef UTM_STEP_LIMIT_EN
    localparam int         MAXS = 4;
`endif

    logic       clk = 1'b0;
    logic       rst_n, load_en, start, clear;
    logic [2:0] load_sym;
    logic [2:0] tbl_state, tbl_sym, tbl_next_state, tbl_new_sym;
    logic       tbl_dir;
    logic [3:0] rd_addr, head_pos;
    logic [2:0] rd_sym;
    logic [7:0] step_count;
    logic       running, halted, fault;

    logic [2:0] tt_next [64];
    logic [2:0] tt_sym  [64];
    logic       tt_dir  [64];

    logic [2:0] mt [TL];
    logic [2:0] ld [32];
    int m_head, m_state, m_commits, m_end;
    int total = 0;
    int bad = 0;
    int edges;

    always #50 clk = ~clk;

    assign tbl_next_state = tt_next[{tbl_state, tbl_sym}];
    assign tbl_new_sym    = tt_sym[{tbl_state, tbl_sym}];
    assign tbl_dir        = tt_dir[{tbl_state, tbl_sym}];

    utm_tape_controller #(
        .TAPE_LEN   (TL),
        .HALT_STATE (HS)
`ifdef UTM_STEP_LIMIT_EN
        ,
        .MAX_STEPS  (MAXS)
`endif
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .load_en        (load_en),
        .load_sym       (load_sym),
        .start          (start),
        .clear          (clear),
        .tbl_state      (tbl_state),
        .tbl_sym        (tbl_sym),
        .tbl_next_state (tbl_next_state),
        .tbl_new_sym    (tbl_new_sym),
        .tbl_dir        (tbl_dir),
        .rd_addr        (rd_addr),
        .rd_sym         (rd_sym),
        .head_pos       (head_pos),
        .step_count     (step_count),
        .running        (running),
        .halted         (halted),
        .fault          (fault)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0; load_en = 1'b0; start = 1'b0; clear = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
        for (int i = 0; i < TL; i++) mt[i] = 3'b000;
    endtask

    task automatic set_const(input logic [2:0] n, input logic [2:0] s, input logic d);
        for (int i = 0; i < 64; i++) begin
            tt_next[i] = n; tt_sym[i] = s; tt_dir[i] = d;
        end
    endtask

    // Serial load; once the pointer reaches the last cell it stays there.
    task automatic load_seq(input int n);
        for (int i = 0; i < n; i++) begin
            load_en = 1'b1; load_sym = ld[i];
            tick();
            mt[(i < TL - 1) ? i : TL - 1] = ld[i];
        end
        load_en = 1'b0;
    endtask

    task automatic chk_tape(input string tag);
        for (int i = 0; i < TL; i++) begin
            rd_addr = 4'(i);
            #1;
            chk({tag, ":tape"}, rd_sym, mt[i]);
        end
    endtask

    // Turing-machine reference: m_end 0=still running, 1=halt, 2=fault, 3=timeout.
    task automatic model_run();
        int idx;
        m_head = 0; m_state = 0; m_commits = 0; m_end = 0;
        while (m_end == 0 && m_commits < LIM) begin
            idx = m_state * 8 + int'(mt[m_head]);
            mt[m_head] = tt_sym[idx];
            m_commits++;
            if (tt_next[idx] == HS) begin
                m_state = HS; m_end = 1;
            end else if ((m_head == 0 && !tt_dir[idx]) || (m_head == TL - 1 && tt_dir[idx])) begin
                m_end = 2;
            end else begin
                m_head  = tt_dir[idx] ? m_head + 1 : m_head - 1;
                m_state = int'(tt_next[idx]);
`ifdef UTM_STEP_LIMIT_EN
                if (m_commits == MAXS) m_end = 3;
`endif
            end
        end
    endtask

    task automatic do_run(input string tag, output int n_edges);
        model_run();
        start = 1'b1;
        tick();
        start = 1'b0;
        chk({tag, ":running"}, running, 1);
        n_edges = 0;
        for (int e = 1; e <= 2 * LIM; e++) begin
            tick();
            n_edges = e;
            if (halted || fault) break;
        end
        if (m_end == 0) begin
            chk({tag, ":still_running"}, {running, halted, fault}, 3'b100);
        end else begin
            chk({tag, ":edges"}, n_edges, 2 * m_commits);
            chk({tag, ":halted"}, halted, (m_end == 1));
            chk({tag, ":fault"}, fault, (m_end >= 2));
            chk({tag, ":stopped"}, running, 0);
        end
        chk({tag, ":head"}, head_pos, m_head);
        chk({tag, ":steps"}, step_count, (m_commits > 255) ? 255 : m_commits);
        chk({tag, ":state"}, tbl_state, m_state);
        chk_tape(tag);
    endtask

    initial begin
        rst_n = 1'b0; load_en = 1'b0; start = 1'b0; clear = 1'b0;
        load_sym = 3'b000; rd_addr = 4'd0;
        set_const(3'd0, 3'd0, 1'b1);

        do_reset();
        chk("rst:running", running, 0);
        chk("rst:halted", halted, 0);
        chk("rst:fault", fault, 0);
        chk("rst:head", head_pos, 0);
        chk("rst:steps", step_count, 0);
        chk("rst:state", tbl_state, 0);
        chk_tape("rst");

        // Two blanks then a 1: walk right writing 1s, halt on the first 1.
        set_const(3'd0, 3'd1, 1'b1);
        tt_next[8'd1] = HS;
        ld[0] = 3'd0; ld[1] = 3'd0; ld[2] = 3'd1;
        load_seq(3);
        do_run("walk", edges);
        chk("walk:latency", edges, 6);
        chk("walk:head", head_pos, 2);
        chk("walk:steps", step_count, 3);

        load_en = 1'b1; load_sym = 3'd5; start = 1'b1;
        tick();
        tick();
        load_en = 1'b0; start = 1'b0;
        chk("halt_hold:halted", halted, 1);
        chk("halt_hold:steps", step_count, 3);
        chk_tape("halt_hold");

        clear = 1'b1;
        tick();
        clear = 1'b0;
        chk("clear:halted", halted, 0);
        chk("clear:running", running, 0);
        chk("clear:steps", step_count, 0);
        chk("clear:head", head_pos, 0);
        chk("clear:state", tbl_state, 0);
        chk("clear:sym", tbl_sym, 1);
        chk_tape("clear");
        ld[0] = 3'd4;
        load_seq(1);
        chk_tape("clear_reload");

        do_reset();
        set_const(3'd1, 3'd2, 1'b0);
        do_run("left_edge", edges);
        chk("left_edge:latency", edges, 2);
        chk("left_edge:fault", fault, 1);
        chk("left_edge:state", tbl_state, 0);
        chk("left_edge:head", head_pos, 0);

        do_reset();
        set_const(3'd0, 3'd3, 1'b1);
        do_run("right_edge", edges);
`ifndef UTM_STEP_LIMIT_EN
        chk("right_edge:steps", step_count, 16);
        chk("right_edge:head", head_pos, 15);
        chk("right_edge:fault", fault, 1);
`endif

        // Reset while the FSM sits in COMMIT (odd edge count after start).
        do_reset();
        start = 1'b1;
        tick();
        start = 1'b0;
        repeat (5) tick();
        chk("midrst:pre_steps", step_count, 2);
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        for (int i = 0; i < TL; i++) mt[i] = 3'b000;
        chk("midrst:running", running, 0);
        chk("midrst:steps", step_count, 0);
        chk("midrst:head", head_pos, 0);
        chk_tape("midrst");

        // Bounce between cells 0 and 1 forever.
        do_reset();
        set_const(3'd0, 3'd0, 1'b1);
        for (int s = 0; s < 8; s++) begin
            tt_next[s] = 3'd1;     tt_sym[s] = 3'd1;     tt_dir[s] = 1'b1;
            tt_next[8 + s] = 3'd0; tt_sym[8 + s] = 3'd2; tt_dir[8 + s] = 1'b0;
        end
        do_run("bounce", edges);
`ifdef UTM_STEP_LIMIT_EN
        chk("bounce:latency", edges, 8);
        chk("bounce:fault", fault, 1);
        chk("bounce:steps", step_count, 4);
`else
        chk("bounce:fault", fault, 0);
        chk("bounce:steps", step_count, 255);
`endif

        for (int r = 0; r < 8; r++) begin
            int n;
            do_reset();
            n = $urandom_range(1, 20);
            for (int i = 0; i < n; i++) ld[i] = 3'($urandom_range(0, 7));
            load_seq(n);
            for (int i = 0; i < 64; i++) begin
                tt_next[i] = ($urandom_range(0, 3) == 0) ? HS : 3'($urandom_range(0, 6));
                tt_sym[i]  = 3'($urandom_range(0, 7));
                tt_dir[i]  = 1'($urandom_range(0, 1));
            end
            do_run("random", edges);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/utm_tape_controller.md
Name: utm_tape_controller

Overview:
- Sequential host for the combinational UTM transition table, driving its {state, symbol} inputs and consuming its {next_state, new_symbol, direction} outputs.
- Owns the tape storage, head pointer, current-state register and step counter.
- Runs the machine one transition at a time until halt or tape fault.
- Sits beside the transition table inside the user module; tape is loaded serially before start and read back afterwards.

Parameters:
- TAPE_LEN, 16, number of tape cells (power of two, ≥4).
- HALT_STATE, 3'd7, state code that stops the machine.
- MAX_STEPS, 255, step budget, used only with UTM_STEP_LIMIT_EN.

Ports:
- clk  in  1  system clock, rising edge
- rst_n  in  1  synchronous active-low reset
- load_en  in  1  write load_sym to tape[load_ptr], then increment load_ptr (IDLE only)
- load_sym  in  3  symbol to load
- start  in  1  begin execution from IDLE
- clear  in  1  return from HALT/FAULT to IDLE
- tbl_state  out  3  current state to table
- tbl_sym  out  3  tape[head] to table
- tbl_next_state  in  3  table next state
- tbl_new_sym  in  3  table symbol to write
- tbl_dir  in  1  table move: 1=right, 0=left
- rd_addr  in  $clog2(TAPE_LEN)  tape readback address
- rd_sym  out  3  tape[rd_addr], combinational
- head_pos  out  $clog2(TAPE_LEN)  head pointer
- step_count  out  8  transitions committed, saturating at 255
- running  out  1  FSM in FETCH or COMMIT
- halted  out  1  FSM in HALT
- fault  out  1  FSM in FAULT or TIMEOUT

Behaviour:
- Reset, sampled at rst_n low on rising clk, valid in any state including mid-run:
  - all tape cells = 3'b000 (blank)
  - state = 0 (A), head = 0, load_ptr = 0, step_count = 0
  - FSM = IDLE
  - running/halted/fault = 0
- tbl_state/tbl_sym always reflect the registered state and tape[head]; the table is purely combinational.
- IDLE:
  - load_en writes tape[load_ptr] and increments load_ptr.
  - At load_ptr == TAPE_LEN-1 the write occurs and the pointer saturates; further loads overwrite the last cell.
  - start → FETCH, or → HALT directly if state == HALT_STATE.
  - If load_en and start are high in the same cycle, the load is performed and start is taken.
- FETCH: one cycle of settling for table inputs → COMMIT unconditionally.
- COMMIT samples the tbl_* inputs:
  - Always: tape[head] ← tbl_new_sym; step_count +1 (saturating).
  - tbl_next_state == HALT_STATE: state ← HALT_STATE, head unchanged → HALT.
  - Else, move off tape (head == 0 and dir == 0, or head == TAPE_LEN-1 and dir == 1): head and state unchanged → FAULT. No wrap-around.
  - Else: head ± 1, state ← tbl_next_state → FETCH.
- Timing: 2 clk per transition. The n-th commit occurs on the 2n-th edge after the edge that accepted start.
- HALT/FAULT:
  - Hold all registers.
  - clear → IDLE with state = 0, head = 0, load_ptr = 0, step_count = 0; tape preserved.
  - start and load_en are ignored.
- clear, start and load_en are ignored in FETCH/COMMIT.
- rd_sym is valid in every state. A same-cycle write shows the old value.

Optional Feature:
- Macro: UTM_STEP_LIMIT_EN.
- Defined:
  - Adds FSM state TIMEOUT.
  - A COMMIT that would otherwise return to FETCH with step_count (post-increment) == MAX_STEPS goes → TIMEOUT; the write and move are still applied.
  - fault = 1 in TIMEOUT; clear exits to IDLE as from FAULT.
- Undefined:
  - No TIMEOUT state and MAX_STEPS is unused.
  - The machine runs until halt or fault; step_count saturates silently.

Decomposition:
- Package utm_pkg:
  - STATE_W = 3, SYM_W = 3, SYM_BLANK = 3'b000, DIR_LEFT/DIR_RIGHT constants.
  - FSM state enum: IDLE, FETCH, COMMIT, HALT, FAULT, TIMEOUT.
- Sub-module utm_tape:
  - TAPE_LEN × 3 register file with synchronous clear.
  - One write port (load or commit, muxed by the controller) and two combinational read ports (head, rd_addr).

Test Plan:
- Reset then rd_sym for all addresses → 3'b000; running/halted/fault = 0; head_pos = 0; step_count = 0.
- Load 000,000,001; bench table: sym 000 → write 001, right, same state; sym 001 → next = HALT_STATE, write 001 → halted = 1 exactly 6 edges after start; head_pos = 2; step_count = 3; tape[0..2] = 001.
- Table always write 010, left, state B; start with head 0 → fault = 1 after 2 edges; tape[0] = 010; tbl_state still 0; head_pos = 0.
- Table always move right, never halt; TAPE_LEN = 16 → fault after 16 commits; head_pos = 15; step_count = 16.
- Assert rst_n low during COMMIT mid-run → next cycle IDLE, tape all blank, step_count = 0. Assert clear after halt → IDLE, tape retained.
- With UTM_STEP_LIMIT_EN and MAX_STEPS = 4, table bouncing right/left forever → fault after 8 edges; step_count = 4. Without the macro, same stimulus → no fault after 600 edges; step_count = 255.
